// File: rtl/simplez_pkg.sv
// Shared definitions for the Simplez core: opcodes, group-7 extended codes and FSM states.
// Assembler-side benches import this package for the same encodings.
package simplez_pkg;

    localparam logic [2:0] OpSt   = 3'd0;
    localparam logic [2:0] OpLd   = 3'd1;
    localparam logic [2:0] OpAdd  = 3'd2;
    localparam logic [2:0] OpBr   = 3'd3;
    localparam logic [2:0] OpBz   = 3'd4;
    localparam logic [2:0] OpClr  = 3'd5;
    localparam logic [2:0] OpDec  = 3'd6;
    localparam logic [2:0] OpGrp7 = 3'd7;

    localparam logic [3:0] CoeHalt = 4'hE;
    localparam logic [3:0] CoeWait = 4'hF;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StExec  = 3'd2,
        StData  = 3'd3,
        StWait  = 3'd4,
        StHalt  = 3'd5
    } state_e;

endpackage

// File: rtl/simplez_wait_timer.sv
// Down-counter for the WAIT instruction: load arms it, ena counts, done flags the last
// counting cycle so the caller spends exactly WAIT_CYCLES cycles with ena high.
module simplez_wait_timer #(
    parameter int unsigned WAIT_CYCLES = 2400000
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic ena,
    output logic done
);

    localparam int unsigned TW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = TW'(WAIT_CYCLES - 1);
        end else if (ena && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    assign done = ena && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/simplez_core.sv
// Simplez accumulator CPU: multi-cycle FSM fetching and executing one instruction at a time
// over a simple req/ack bus; peripherals are decoded outside on the bus.
module simplez_core
    import simplez_pkg::*;
#(
    parameter int unsigned AW          = 9,
    parameter int unsigned WAIT_CYCLES = 2400000,
    parameter int unsigned RESET_PC    = 0,
    localparam int unsigned DW         = AW + 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          run,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    output logic [DW-1:0] acc,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          waiting
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          z_q, z_d;
    logic          halted_q, halted_d;

    logic [2:0]    co;
    logic [3:0]    coe;
    logic [AW-1:0] cd;
    logic [AW-1:0] pc_inc;
    logic          timer_load, timer_ena, timer_done;

    assign co     = ir_q[DW-1:DW-3];
    assign coe    = ir_q[DW-1:DW-4];
    assign cd     = ir_q[AW-1:0];
    assign pc_inc = pc_q + AW'(1);

    simplez_wait_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_timer (
        .clk  (clk),
        .rstn (rstn),
        .load (timer_load),
        .ena  (timer_ena),
        .done (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        acc_d      = acc_q;
        z_d        = z_q;
        halted_d   = halted_q;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = pc_q;
        timer_load = 1'b0;
        timer_ena  = 1'b0;

        case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                bus_req = 1'b1;
                if (bus_ack) begin
                    ir_d    = bus_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StIdle;
                unique case (co)
                    OpSt, OpLd, OpAdd: state_d = StData;
                    OpBr:  pc_d = cd;
                    OpBz:  pc_d = z_q ? cd : pc_inc;
                    OpClr: begin
                        acc_d = '0;
                        z_d   = 1'b1;
                        pc_d  = pc_inc;
                    end
                    OpDec: begin
                        acc_d = acc_q - DW'(1);
                        z_d   = (acc_d == '0);
                        pc_d  = pc_inc;
                    end
                    default: begin
                        // Group 7: bit 0 of the extended code selects WAIT over HALT.
                        if (coe == CoeHalt) begin
                            halted_d = 1'b1;
                            state_d  = StHalt;
                        end else begin
                            timer_load = 1'b1;
                            state_d    = StWait;
                        end
                    end
                endcase
            end
            StData: begin
                bus_req  = 1'b1;
                bus_addr = cd;
                bus_we   = (co == OpSt);
                if (bus_ack) begin
                    if (co == OpLd) begin
                        acc_d = bus_rdata;
                        z_d   = (acc_d == '0);
                    end else if (co == OpAdd) begin
                        acc_d = acc_q + bus_rdata;
                        z_d   = (acc_d == '0);
                    end
                    pc_d    = pc_inc;
                    state_d = StIdle;
                end
            end
            StWait: begin
                timer_ena = 1'b1;
                if (timer_done) begin
                    pc_d    = pc_inc;
                    state_d = StIdle;
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            pc_q     <= AW'(RESET_PC);
            ir_q     <= '0;
            acc_q    <= '0;
            z_q      <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            acc_q    <= acc_d;
            z_q      <= z_d;
            halted_q <= halted_d;
        end
    end

    assign bus_wdata = acc_q;
    assign acc       = acc_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign waiting   = (state_q == StWait);

endmodule

// File: tb/tb_simplez_core.sv
// Self-checking bench for simplez_core: directed programs plus random forward-branching
// programs compared against an instruction-level reference model.
module tb_simplez_core;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 12;
    localparam int unsigned WC = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          run = 1'b0;
    logic          bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ack = 1'b0;
    logic [DW-1:0] acc;
    logic [AW-1:0] pc;
    logic          halted, waiting;

    simplez_core #(
        .AW          (AW),
        .WAIT_CYCLES (WC),
        .RESET_PC    (0)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .run       (run),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .acc       (acc),
        .pc        (pc),
        .halted    (halted),
        .waiting   (waiting)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem     [512];
    logic [DW-1:0] ref_mem [512];
    logic [DW-1:0] exp_acc;
    logic [AW-1:0] exp_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus slave: decides ack on the falling edge so it is stable at the next rising edge.
    bit            slave_en = 1'b0;
    int            lat_mode = 0;
    int            s_cnt = 0;
    int            s_lat = 0;
    bit            s_was_ack = 1'b0;
    logic [AW-1:0] h_addr;
    logic          h_we;
    logic [DW-1:0] h_wdata;

    always @(negedge clk) begin
        if (slave_en) begin
            if (s_was_ack) check("req_falls_after_ack", bus_req, 0);
            if (!bus_req) begin
                bus_ack   = 1'b0;
                s_cnt     = 0;
                s_was_ack = 1'b0;
            end else begin
                if (s_cnt == 0) begin
                    h_addr  = bus_addr;
                    h_we    = bus_we;
                    h_wdata = bus_wdata;
                    s_lat   = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                end else begin
                    check("stable_addr", bus_addr, h_addr);
                    check("stable_we", bus_we, h_we);
                    if (h_we) check("stable_wdata", bus_wdata, h_wdata);
                end
                if (s_cnt >= s_lat) begin
                    bus_ack = 1'b1;
                    if (bus_we) mem[bus_addr] = bus_wdata;
                    else bus_rdata = mem[bus_addr];
                    s_was_ack = 1'b1;
                end else begin
                    bus_ack = 1'b0;
                end
                s_cnt++;
            end
        end
    end

    function automatic logic [DW-1:0] enc(input logic [2:0] op, input logic [AW-1:0] cd);
        return {op, cd};
    endfunction

    // Instruction-level model: runs the program in ref_mem until HALT.
    task automatic ref_run();
        logic [AW-1:0] p = '0;
        logic [DW-1:0] a = '0;
        bit            zz = 1'b0;
        logic [DW-1:0] ins;
        logic [AW-1:0] t;
        ref_mem = mem;
        for (int s = 0; s < 1000; s++) begin
            ins = ref_mem[p];
            t   = ins[AW-1:0];
            case (ins[11:9])
                3'd0: begin ref_mem[t] = a; p++; end
                3'd1: begin a = ref_mem[t]; zz = (a == 0); p++; end
                3'd2: begin a = a + ref_mem[t]; zz = (a == 0); p++; end
                3'd3: p = t;
                3'd4: p = zz ? t : p + 1;
                3'd5: begin a = 0; zz = 1'b1; p++; end
                3'd6: begin a = a - 1; zz = (a == 0); p++; end
                default: begin
                    if (ins[8]) p++;
                    else break;
                end
            endcase
        end
        exp_acc = a;
        exp_pc  = p;
    endtask

    task automatic do_reset(input string tag);
        run  = 1'b0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_rst_req"}, bus_req, 0);
        check({tag, "_rst_wait"}, waiting, 0);
        check({tag, "_rst_halt"}, halted, 0);
        check({tag, "_rst_acc"}, acc, 0);
        check({tag, "_rst_pc"}, pc, 0);
        rstn = 1'b1;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_halted"}, halted, 1);
    endtask

    task automatic quiet_after_halt(input string tag);
        int hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus_req) hits++;
        end
        check({tag, "_no_req_after_halt"}, hits, 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = '0;
    endtask

    task automatic add_prog(input int lat, input string tag);
        clear_mem();
        mem[10] = 12'd5;
        mem[11] = 12'd7;
        mem[0]  = enc(3'd1, 9'd10);
        mem[1]  = enc(3'd2, 9'd11);
        mem[2]  = enc(3'd0, 9'd12);
        mem[3]  = 12'hE00;
        lat_mode = lat;
        slave_en = 1'b1;
        do_reset(tag);
        run = 1'b1;
        wait_halt(tag);
        check({tag, "_mem12"}, mem[12], 12);
        check({tag, "_acc"}, acc, 12);
        check({tag, "_pc"}, pc, 3);
        quiet_after_halt(tag);
    endtask

    initial begin
        int n, wcnt;
        int          plen;
        int          r;
        int unsigned tgt;

        add_prog(0, "add0w");
        add_prog(3, "add3w");

        // CLR, DEC, BZ 0x20, CLR, BZ 0x30
        clear_mem();
        mem[0]    = enc(3'd5, 9'd0);
        mem[1]    = enc(3'd6, 9'd0);
        mem[2]    = enc(3'd4, 9'h20);
        mem[3]    = enc(3'd5, 9'd0);
        mem[4]    = enc(3'd4, 9'h30);
        mem[9'h20] = 12'hE00;
        mem[9'h30] = 12'hE00;
        lat_mode = 0;
        do_reset("bz");
        run = 1'b1;
        n = 0;
        while (pc != 2 && n < 200) begin @(posedge clk); #1; n++; end
        check("bz_acc_after_dec", acc, 12'hFFF);
        n = 0;
        while (pc == 2 && n < 200) begin @(posedge clk); #1; n++; end
        check("bz_first_not_taken", pc, 3);
        wait_halt("bz");
        check("bz_second_taken", pc, 9'h30);
        check("bz_acc_end", acc, 0);

        // WAIT then HALT
        clear_mem();
        mem[0] = 12'hF00;
        mem[1] = 12'hE00;
        do_reset("wait");
        run = 1'b1;
        wcnt = 0;
        n = 0;
        while (!halted && n < 300) begin
            @(posedge clk);
            #1;
            if (waiting) wcnt++;
            n++;
        end
        check("wait_halted", halted, 1);
        check("wait_cycles", wcnt, WC);
        check("wait_pc", pc, 1);

        // run dropped during a data transfer
        clear_mem();
        mem[10] = 12'd5;
        mem[11] = 12'd7;
        mem[0]  = enc(3'd1, 9'd10);
        mem[1]  = enc(3'd2, 9'd11);
        mem[2]  = 12'hE00;
        lat_mode = 3;
        do_reset("pause");
        run = 1'b1;
        n = 0;
        while (!(bus_req && bus_addr == 10) && n < 200) begin @(posedge clk); #1; n++; end
        check("pause_saw_data", bus_addr, 10);
        run = 1'b0;
        wcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (i >= 6 && bus_req) wcnt++;
        end
        check("pause_idle_no_req", wcnt, 0);
        check("pause_acc", acc, 5);
        check("pause_pc", pc, 1);
        run = 1'b1;
        @(posedge clk);
        #1;
        check("pause_resume_req", bus_req, 1);
        check("pause_resume_addr", bus_addr, 1);
        wait_halt("pause");
        check("pause_final_acc", acc, 12);

        // reset with a transfer outstanding; a late ack must do nothing
        clear_mem();
        mem[10] = 12'd5;
        mem[0]  = enc(3'd1, 9'd10);
        mem[1]  = 12'hE00;
        do_reset("abort");
        slave_en  = 1'b0;
        s_cnt     = 0;
        s_was_ack = 1'b0;
        bus_ack   = 1'b0;
        run = 1'b1;
        n = 0;
        while (!bus_req && n < 50) begin @(posedge clk); #1; n++; end
        check("abort_fetch_addr", bus_addr, 0);
        bus_rdata = enc(3'd1, 9'd10);
        bus_ack   = 1'b1;
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        @(posedge clk);
        #1;
        check("abort_data_req", bus_req, 1);
        check("abort_data_addr", bus_addr, 10);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("abort_req_drops", bus_req, 0);
        bus_rdata = 12'h123;
        bus_ack   = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_acc", acc, 0);
        check("abort_pc", pc, 0);
        check("abort_idle_req", bus_req, 0);
        bus_ack  = 1'b0;
        slave_en = 1'b1;
        run = 1'b1;
        @(posedge clk);
        #1;
        check("abort_refetch_req", bus_req, 1);
        check("abort_refetch_addr", bus_addr, 0);
        wait_halt("abort");
        check("abort_final_acc", acc, 5);

        // random forward-branching programs, random slave latency
        lat_mode = -1;
        for (int k = 0; k < 20; k++) begin
            clear_mem();
            plen = $urandom_range(6, 14);
            for (int i = 100; i < 108; i++) mem[i] = DW'($urandom);
            for (int i = 0; i < plen - 1; i++) begin
                r   = $urandom_range(0, 9);
                tgt = $urandom_range(i + 1, plen - 1);
                case (r)
                    0, 1:    mem[i] = enc(3'd1, 9'(100 + $urandom_range(0, 7)));
                    2, 3:    mem[i] = enc(3'd2, 9'(100 + $urandom_range(0, 7)));
                    4:       mem[i] = enc(3'd0, 9'(100 + $urandom_range(0, 7)));
                    5:       mem[i] = enc(3'd5, 9'd0);
                    6:       mem[i] = enc(3'd6, 9'd0);
                    7:       mem[i] = enc(3'd4, 9'(tgt));
                    8:       mem[i] = enc(3'd3, 9'(tgt));
                    default: mem[i] = 12'hF00;
                endcase
            end
            mem[plen-1] = 12'hE00;
            ref_run();
            do_reset("rnd");
            run = 1'b1;
            wait_halt("rnd");
            check("rnd_acc", acc, exp_acc);
            check("rnd_pc", pc, exp_pc);
            for (int i = 100; i < 108; i++) check("rnd_mem", mem[i], ref_mem[i]);
            quiet_after_halt("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/simplez_core.md
SIMPLEZ_CORE -- requirements
Module: simplez_core

Interface
REQ-001 The block SHALL have the parameter AW, default 9, meaning address width; DW SHALL be a derived constant equal to AW+3.
REQ-002 The block SHALL have the parameter WAIT_CYCLES, default 2400000, meaning the WAIT instruction duration in clk cycles (minimum 1).
REQ-003 The block SHALL have the parameter RESET_PC, default 0, meaning the PC value after reset.
REQ-004 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rstn  in  1  reset; synchronous, active-low.
REQ-006 run  in  1  when low, the core SHALL pause before the next instruction fetch.
REQ-007 bus_req  out  1  bus transfer request.
REQ-008 bus_we  out  1  1 = write, 0 = read; valid while bus_req=1.
REQ-009 bus_addr  out  AW  transfer address.
REQ-010 bus_wdata  out  DW  write data; equals the accumulator value.
REQ-011 bus_rdata  in  DW  read data; valid in the bus_ack cycle.
REQ-012 bus_ack  in  1  transfer complete; sampled only while bus_req=1.
REQ-013 acc  out  DW  accumulator, for debug and LEDs.
REQ-014 pc  out  AW  program counter.
REQ-015 halted  out  1  high after HALT executes.
REQ-016 waiting  out  1  high while a WAIT instruction is counting.

Function
REQ-017 Instruction fields SHALL be: CO = ir[DW-1:DW-3]; COE = ir[DW-1:DW-4]; CD = ir[AW-1:0].
REQ-018 Opcodes SHALL be: ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, group 7.
REQ-019 In group 7, COE=4'hE SHALL execute HALT and COE=4'hF SHALL execute WAIT.
REQ-020 The state machine SHALL have the states IDLE, FETCH, EXEC, DATA, WAIT, HALT.
REQ-021 IDLE SHALL go to FETCH when run=1 and SHALL otherwise stay in IDLE with bus_req=0.
REQ-022 FETCH SHALL hold bus_req=1, bus_we=0, bus_addr=pc; on bus_ack it SHALL set ir to bus_rdata and go to EXEC.
REQ-023 EXEC decode for ST, LD, ADD: go to DATA with bus_addr=CD and bus_we=1 for ST, 0 otherwise.
REQ-024 EXEC decode for BR: pc SHALL become CD.
REQ-025 EXEC decode for BZ: pc SHALL become CD if z=1, else pc+1.
REQ-026 EXEC decode for CLR: acc SHALL become 0 and pc SHALL become pc+1.
REQ-027 EXEC decode for DEC: acc SHALL become acc-1 and pc SHALL become pc+1.
REQ-028 EXEC decode for HALT: go to HALT and set halted=1.
REQ-029 EXEC decode for WAIT: load the timer and go to WAIT.
REQ-030 BR, BZ, CLR and DEC SHALL return to IDLE.
REQ-031 DATA SHALL hold bus_req=1; on bus_ack, LD SHALL set acc to bus_rdata, ADD SHALL set acc to acc+bus_rdata, and ST SHALL only complete; pc SHALL then become pc+1 and the state SHALL go to IDLE.
REQ-032 WAIT SHALL count WAIT_CYCLES cycles, then set pc to pc+1 and go to IDLE; waiting SHALL be 1 only in WAIT.
REQ-033 HALT SHALL be absorbing, leaving only via reset; bus_req SHALL be 0 in HALT.
REQ-034 Bus handshake: bus_addr, bus_we and bus_wdata SHALL be stable from the rise of bus_req until the bus_ack cycle.
REQ-035 A zero-wait slave MAY assert bus_ack in the first request cycle.
REQ-036 bus_req SHALL fall in the cycle after bus_ack; back-to-back requests SHALL be separated by at least one cycle.
REQ-037 Arithmetic SHALL be modulo 2^DW: ADD wraps, and DEC of 0 gives all ones.
REQ-038 pc SHALL wrap from 2^AW-1 to 0.
REQ-039 The z flag SHALL be updated on every acc write only, set to (new acc == 0); ST, branches and WAIT SHALL leave z unchanged.
REQ-040 run SHALL be sampled only in IDLE; deasserting run mid-instruction SHALL complete that instruction.
REQ-041 A bus_ack received outside FETCH or DATA SHALL be ignored.

Reset
REQ-042 While rstn=0 at a clock edge: state=IDLE, pc=RESET_PC, ir=0, acc=0, z=0, halted=0, timer=0.
REQ-043 While rstn=0, bus_req and waiting SHALL be 0 in the next cycle.
REQ-044 A reset during an outstanding transfer SHALL abort it; bus_req SHALL fall in the next cycle and any ack in flight SHALL have no effect.
REQ-045 After reset release, the first fetch request SHALL appear one cycle after IDLE sees run=1.

Structure
REQ-046 Opcode values, COE values and state encodings SHALL reside in the shared header simplez.vh, to be reused by the assembler-side testbench.
REQ-047 The WAIT counter SHALL be one sub-module, simplez_wait_timer, parameterised by WAIT_CYCLES, with inputs load and ena and output done.
REQ-048 Peripheral address decoding SHALL NOT be part of this block; it SHALL reside outside the core on the bus.

Verification
REQ-049 AW=9, zero-wait RAM; mem[10]=5, mem[11]=7; program LD 10, ADD 11, ST 12, HALT -> mem[12]=12, acc=12, halted=1, z=0, no bus_req after HALT.
REQ-050 Same program with a slave acking 3 cycles after bus_req rises -> identical result; bus_addr, bus_we and bus_wdata constant over every request; checked by assertion.
REQ-051 Program CLR, DEC, BZ 0x20, CLR, BZ 0x30 -> acc=0xFFF and z=0 after DEC; first BZ not taken; second BZ taken, so the next fetch address is 0x30.
REQ-052 WAIT_CYCLES=8, program WAIT, HALT -> waiting=1 for exactly 8 cycles; HALT fetch follows; pc increments by one.
REQ-053 run=0 asserted during a DATA transfer -> the transfer completes, the core stays in IDLE with bus_req=0; run=1 -> the fetch resumes at the next pc.
REQ-054 rstn=0 while bus_req=1 with ack pending, ack then given -> acc, pc and memory unchanged from reset values; restart fetches from RESET_PC.
